// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: shifts one MSB-first word out on mosi while capturing miso,
// framed by cs_n, with a start/ready/done handshake towards the local logic.
module spi_master_tx #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HALF_PER = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned HCNT_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int unsigned BCNT_W = $clog2(DATA_W);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HALF_PER - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

  state_e            state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              half_end;

  assign half_end = (hcnt_q == HCNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LEAD;
      LEAD:    if (half_end) state_d = SHIFT;
      SHIFT:   if (half_end && sck_q && (bcnt_q == BCNT_LAST)) state_d = TRAIL;
      TRAIL:   if (half_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shifters and registered pin values for the next cycle
  always_comb begin
    hcnt_d    = hcnt_q;
    bcnt_d    = bcnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sh_d = tx_data;
          mosi_d  = tx_data[DATA_W-1];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          sck_d   = 1'b0;
          hcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      LEAD: begin
        if (half_end) begin
          hcnt_d  = '0;
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      SHIFT: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end else begin
          hcnt_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
            // Rotate rather than shift so the word stays intact; mosi follows the next-lower bit.
            if (bcnt_q != BCNT_LAST) begin
              bcnt_d  = bcnt_q + BCNT_W'(1);
              mosi_d  = tx_sh_q[DATA_W-2];
              tx_sh_d = {tx_sh_q[DATA_W-2:0], tx_sh_q[DATA_W-1]};
            end
          end else begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
          end
        end
      end
      TRAIL: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end else begin
          hcnt_d    = '0;
          bcnt_d    = '0;
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          ready_d   = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      bcnt_q    <= bcnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign sck     = sck_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign ready   = ready_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: an 8-bit/HALF_PER=2 and a 4-bit/HALF_PER=1 instance,
// each compared every cycle against a timing model derived from the transaction formulas.
module tb_spi_master_tx;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] start, ready, done, sck, cs_n, mosi, miso;
  logic [7:0]   txd [N];
  logic [7:0]   rx0;
  logic [3:0]   rx1;
  logic [7:0]   rx_obs [N];
  logic         loop0;
  logic [7:0]   pword;
  logic [7:0]   psh = 8'h00;
  logic [7:0]   prx = 8'h00;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  spi_master_tx #(.DATA_W(8), .HALF_PER(2)) u_dut8 (
    .clk(clk), .reset(reset), .start(start[0]), .tx_data(txd[0]),
    .ready(ready[0]), .done(done[0]), .rx_data(rx0),
    .sck(sck[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master_tx #(.DATA_W(4), .HALF_PER(1)) u_dut4 (
    .clk(clk), .reset(reset), .start(start[1]), .tx_data(txd[1][3:0]),
    .ready(ready[1]), .done(done[1]), .rx_data(rx1),
    .sck(sck[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  assign rx_obs[0] = rx0;
  assign rx_obs[1] = {4'h0, rx1};
  assign miso[0]   = loop0 ? mosi[0] : psh[7];
  assign miso[1]   = mosi[1];

  // Mode-0 peripheral on the 8-bit link: first bit valid at cs_n fall, next bit on each sck fall.
  always @(negedge cs_n[0]) psh = pword;
  always @(negedge sck[0]) if (!cs_n[0]) psh = {psh[6:0], 1'b0};
  always @(posedge sck[0]) prx = {prx[6:0], mosi[0]};

  function automatic int dw_of(input int d);
    return (d == 0) ? 8 : 4;
  endfunction
  function automatic int hp_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int td_of(input int d);
    return 1 + (2 * dw_of(d) + 1) * hp_of(d);
  endfunction
  function automatic logic [7:0] mask_of(input int d);
    return (d == 0) ? 8'hFF : 8'h0F;
  endfunction

  // Expected {cs_n, sck, mosi, done} n cycles after the accepting edge.
  function automatic logic [3:0] exp_pins(input int n, input int dw, input int hp, input logic [7:0] w);
    int  td;
    int  j;
    logic s;
    td = 1 + (2 * dw + 1) * hp;
    if (n >= td) return 4'b1001;
    s = (n >= 1 + hp) && (n < 1 + 2 * dw * hp) && ((((n - 1 - hp) / hp) % 2) == 0);
    j = (n - 1) / (2 * hp);
    if (j > dw - 1) j = dw - 1;
    return {1'b0, s, w[dw-1-j], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view (active flag, cycle offset, word, expected rx).
  bit         m_act [N];
  int         m_n   [N];
  logic [7:0] m_w   [N];
  logic [7:0] m_src [N];
  logic [7:0] m_rx  [N];
  bit         acc_m;

  always @(posedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (!reset) begin
        m_act[d] = 1'b0;
        m_n[d]   = 0;
        m_rx[d]  = 8'h00;
      end else begin
        acc_m = start[d] && (!m_act[d] || m_n[d] == td_of(d));
        if (m_act[d] && m_n[d] == td_of(d)) m_act[d] = 1'b0;
        if (acc_m) begin
          m_act[d] = 1'b1;
          m_n[d]   = 1;
          m_w[d]   = txd[d] & mask_of(d);
          m_src[d] = (d == 0 && !loop0) ? pword : m_w[d];
        end else if (m_act[d]) begin
          m_n[d]++;
          if (m_n[d] == td_of(d)) m_rx[d] = m_src[d];
        end
      end
    end
  end

  logic prev_mosi [N];
  logic prev_cs   [N];
  logic [3:0] e_pins;
  logic       e_rdy;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < N; d++) begin
        e_pins = m_act[d] ? exp_pins(m_n[d], dw_of(d), hp_of(d), m_w[d]) : 4'b1000;
        e_rdy  = !m_act[d] || (m_n[d] == td_of(d));
        chk($sformatf("pins%0d{cs_n,sck,mosi,done}", d), {cs_n[d], sck[d], mosi[d], done[d]}, e_pins);
        chk($sformatf("ready%0d", d), ready[d], e_rdy);
        chk($sformatf("rx_data%0d", d), rx_obs[d], m_rx[d]);
        if (mosi[d] !== prev_mosi[d] && !cs_n[d] && !prev_cs[d])
          chk($sformatf("mosi%0d_change_sck_low", d), sck[d], 1'b0);
        prev_mosi[d] = mosi[d];
        prev_cs[d]   = cs_n[d];
      end
    end
  end

  task automatic wait_done(input int d, input int n0, output int lat);
    lat = -1;
    for (int n = n0; n <= n0 + 80; n++) begin
      if (n > n0) @(negedge clk);
      if (done[d]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_one(input int d, input logic [7:0] tx, output int lat);
    @(negedge clk);
    txd[d]   = tx;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    txd[d]   = 8'($urandom);
    wait_done(d, 1, lat);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] pw;
    bit         lp;
    logic [7:0] exp_rx;
    logic [7:0] exp_prx;
  } vec_t;

  vec_t vt [$];
  vec_t v;
  int   lat;
  int   seen;
  int   k, n, last;
  bit   pend;
  logic [7:0] words [3];
  logic [7:0] w4;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = '0;
    txd[0] = 8'h00;
    txd[1] = 8'h00;
    loop0 = 1'b1;
    pword = 8'h00;
    for (int d = 0; d < N; d++) begin
      prev_mosi[d] = 1'b0;
      prev_cs[d]   = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("reset%0d{cs_n,sck,mosi,done,ready}", d),
          {cs_n[d], sck[d], mosi[d], done[d], ready[d]}, 5'b10001);
      chk($sformatf("reset%0d_rx", d), rx_obs[d], 8'h00);
    end
    reset = 1'b1;

    vt.push_back('{8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5});
    vt.push_back('{8'hC3, 8'h3C, 1'b0, 8'h3C, 8'hC3});
    vt.push_back('{8'h00, 8'hFF, 1'b0, 8'hFF, 8'h00});
    vt.push_back('{8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF});
    for (int i = 0; i < 6; i++) begin
      v.tx      = 8'($urandom);
      v.pw      = 8'($urandom);
      v.lp      = 1'($urandom_range(0, 1));
      v.exp_rx  = v.lp ? v.tx : v.pw;
      v.exp_prx = v.tx;
      vt.push_back(v);
    end
    foreach (vt[i]) begin
      loop0 = vt[i].lp;
      pword = vt[i].pw;
      run_one(0, vt[i].tx, lat);
      chk($sformatf("vec%0d_done_latency", i), lat, 35);
      chk($sformatf("vec%0d_rx_data", i), rx0, vt[i].exp_rx);
      chk($sformatf("vec%0d_periph_rx", i), prx, vt[i].exp_prx);
    end

    // start while busy is ignored
    loop0 = 1'b1;
    @(negedge clk); txd[0] = 8'h5A; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (9) @(negedge clk);
    start[0] = 1'b1; txd[0] = 8'hFF;
    @(negedge clk); start[0] = 1'b0;
    wait_done(0, 11, lat);
    chk("busy_start_latency", lat, 35);
    chk("busy_start_rx", rx0, 8'h5A);

    // reset mid-transaction
    @(negedge clk); txd[0] = 8'h6B; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort{cs_n,sck,mosi,ready}", {cs_n[0], sck[0], mosi[0], ready[0]}, 4'b1001);
    chk("abort_rx", rx0, 8'h00);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_one(0, 8'h96, lat);
    chk("after_abort_latency", lat, 35);
    chk("after_abort_rx", rx0, 8'h96);

    // start held high: three back-to-back words
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    @(negedge clk); txd[0] = words[0]; start[0] = 1'b1;
    k = 0; n = 0; last = 0; pend = 1'b0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) txd[0] = words[1];
      if (pend) begin
        pend = 1'b0;
        chk($sformatf("b2b_gap%0d_cs_n", k), cs_n[0], 1'b0);
        if (k == 1) txd[0] = words[2];
        if (k == 2) start[0] = 1'b0;
      end
      if (done[0]) begin
        chk($sformatf("b2b_spacing%0d", k), n - last, 35);
        chk($sformatf("b2b_rx%0d", k), rx0, words[k]);
        chk($sformatf("b2b_done_cs_n%0d", k), cs_n[0], 1'b1);
        last = n;
        k++;
        pend = 1'b1;
      end
    end
    start[0] = 1'b0;
    chk("b2b_words_done", k, 3);
    repeat (40) @(negedge clk);

    // 4-bit, HALF_PER=1 instance
    run_one(1, 8'h09, lat);
    chk("w4_done_latency", lat, 10);
    chk("w4_rx", rx_obs[1], 8'h09);
    for (int i = 0; i < 6; i++) begin
      w4 = 8'($urandom_range(0, 15));
      run_one(1, w4, lat);
      chk($sformatf("w4_rand%0d_latency", i), lat, 10);
      chk($sformatf("w4_rand%0d_rx", i), rx_obs[1], w4);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI controller (initiator) for the opposite end of the FPGA's SPI peripheral link (sck/sdi/sdo).
- Drives sck, chip select and serial data out, and captures serial data in.
- Used for a board-level link test and for the bench model that feeds pixel/command words to the FPGA.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, one word per transaction, with a start/ready/done handshake to the local logic.

Parameters:
- DATA_W, 8, bits per transaction; legal values are 2 or more.
- HALF_PER, 2, clk cycles per sck half-period; legal values are 1 or more. sck frequency = f_clk/(2*HALF_PER).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- start  input  1  request a transaction; honoured only when ready=1.
- tx_data  input  DATA_W  word to send; captured on the accepting cycle.
- ready  output  1  1 when idle and able to accept start.
- done  output  1  one-cycle pulse when a transaction completes.
- rx_data  output  DATA_W  word received; updated on the done cycle and held until the next done.
- sck  output  1  serial clock; idle low.
- cs_n  output  1  active-low chip select; idle high.
- mosi  output  1  serial data to peripheral (peripheral's sdi).
- miso  input  1  serial data from peripheral (peripheral's sdo).

Behaviour:
Reset (reset=0 at a clk edge), next cycle:
- sck=0, cs_n=1, mosi=0, ready=1, done=0, rx_data=0.
- State IDLE; all counters 0.
- Reset mid-transaction aborts immediately with the same values; no done pulse.

States: IDLE, LEAD, SHIFT, TRAIL.
- IDLE: ready=1. If start=1 at edge T0:
  - latch tx_data into the shift register;
  - at T0+1: cs_n=0, mosi=tx_data[DATA_W-1], sck=0, ready=0; go to LEAD.
- LEAD: holds HALF_PER cycles, then enters SHIFT with the first sck rise.
- SHIFT timing: rising edge k (k=0..DATA_W-1) at T0+1+HALF_PER+2k*HALF_PER; falling edge k at T0+1+2(k+1)*HALF_PER.
- On each sck rise: sample miso into the receive register LSB (shift left).
- On each sck fall except the last: mosi takes the next lower tx bit.
  - mosi therefore changes only while sck is low.
  - mosi is stable for HALF_PER cycles before every rise.
- After the last fall (T0+1+2*DATA_W*HALF_PER): mosi holds its last bit; go to TRAIL.
- TRAIL: sck=0 for HALF_PER cycles. At cycle Td = T0+1+(2*DATA_W+1)*HALF_PER:
  - cs_n=1, done=1, rx_data = received word, ready=1, state IDLE.
  - mosi returns to 0 at Td.
- Exactly DATA_W sck rising edges per transaction; sck never toggles while cs_n=1.

Handshake and boundary cases:
- start while ready=0 is ignored; no queuing.
- tx_data changes after acceptance have no effect.
- start=1 on the done cycle Td is accepted (ready=1 that cycle): cs_n is high for exactly one cycle (Td), then low at Td+1.
- start held high continuously produces back-to-back transactions with one-cycle cs_n gaps.
- HALF_PER=1: sck toggles every clk cycle; the same formulas hold.
- Counters are sized clog2 of their range; no wrap-around is allowed within a transaction.
- miso is sampled on the same clk edge that drives sck high (the peripheral samples sdi on sck rise and drives sdo on sck fall).

Test Plan:
- Loopback, DATA_W=8, HALF_PER=2: mosi tied to miso, start at T0 with tx_data=0xA5.
  - Expect cs_n low T0+1..T0+34.
  - Expect 8 sck rises at T0+3,7,...,31.
  - Expect done=1 only at T0+35 and rx_data=0xA5.
- Peripheral model shifting out 0x3C on sck fall, tx_data=0xC3.
  - Expect model receives 0xC3 and rx_data=0x3C.
  - Check mosi changes only while sck=0.
- start pulsed at T0+10 during a busy transaction with tx_data=0xFF.
  - Expect it ignored, and the original transaction completes with unchanged bits and timing.
- reset=0 at T0+12 mid-transaction.
  - Expect next cycle sck=0, cs_n=1, mosi=0, ready=1, rx_data=0.
  - Expect no done pulse.
  - A new start afterwards completes normally.
- start held high for 3 words (0x01, 0x80, 0xFF).
  - Expect 3 done pulses 35 cycles apart, cs_n high exactly one cycle between words, and rx_data matching each word in loopback.
- HALF_PER=1, DATA_W=4, tx_data=0x9, loopback.
  - Expect sck toggling each cycle, done at T0+10, rx_data=0x9.
